// File: rtl/modport_apb_slave.sv
// APB slave target: four one-hot-selected word banks behind a two-phase
// (setup + access) APB cycle with no wait states. Reads are fetched at the
// setup edge so Prdata is stable for the whole access cycle. Writes commit
// at the access edge.
module modport_apb_slave #(
  parameter int NSLV   = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              Hresetn,
  input  logic [NSLV-1:0]   Pselx,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [31:0]       Paddr,
  input  logic [DATA_W-1:0] Pwdata,
  output logic [DATA_W-1:0] Prdata,
  output logic              sel_err
);

  localparam int SEL_W = (NSLV  > 1) ? $clog2(NSLV)  : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // SETUP is the state during the access cycle (setup inputs already latched);
  // ACCESS is the cycle after the access edge, where a new setup may arrive.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  bank [NSLV][DEPTH];

  // Transfer context latched in the setup phase.
  logic [SEL_W-1:0]   sel_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic               ok_q;

  logic               sel_nz;
  logic               sel_onehot;
  logic [SEL_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   addr_idx;
  logic               start;
  logic               do_write;

  // Only the word-index bits of Paddr carry meaning; the rest is ignored.
  logic               unused_paddr;
  assign unused_paddr = ^{Paddr[31:IDX_W+2], Paddr[1:0]};

  assign sel_nz     = |Pselx;
  assign sel_onehot = ($countones(Pselx) == 1);
  assign addr_idx   = Paddr[IDX_W+1:2];

  // Encode the one-hot select into a bank index.
  always_comb begin
    // NOTE: default first so every path assigns sel_idx and no latch is inferred.
    sel_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (Pselx[i]) sel_idx = SEL_W'(i);
    end
  end

  // A setup phase is recognised only outside the access cycle; Penable high
  // without a prior setup is ignored.
  assign start = (state != SETUP) && sel_nz && !Penable;

  // The write commits only when the select is still the legal one latched at setup.
  assign do_write = (state == SETUP) && Penable && wr_q && ok_q &&
                    sel_onehot && (sel_idx == sel_q);

  // Protocol FSM with registered read data and select-error flag.
  always_ff @(posedge clk or negedge Hresetn) begin
    if (!Hresetn) begin
      state   <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      ok_q    <= 1'b0;
      Prdata  <= '0;
      sel_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE, ACCESS: begin
          if (start) begin
            state <= SETUP;
            sel_q <= sel_idx;
            idx_q <= addr_idx;
            wr_q  <= Pwrite;
            ok_q  <= sel_onehot;
            if (sel_onehot) begin
              sel_err <= 1'b0;
              if (!Pwrite) Prdata <= bank[sel_idx][addr_idx];
            end else begin
              Prdata  <= '0;
              sel_err <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        SETUP:   state <= ACCESS;
        default: state <= IDLE;
      endcase
    end
  end

  // Register banks; written only at a legal access edge.
  always_ff @(posedge clk or negedge Hresetn) begin
    if (!Hresetn) begin
      // NOTE: the banks are flops, not RAM, because they must read back zero after reset.
      for (int s = 0; s < NSLV; s++) begin
        for (int w = 0; w < DEPTH; w++) begin
          bank[s][w] <= '0;
        end
      end
    end else if (do_write) begin
      bank[sel_q][idx_q] <= Pwdata;
    end
  end

endmodule

// File: tb/tb_modport_apb_slave.sv
// Testbench for modport_apb_slave: a stimulus process issues APB transfers and
// pushes the expected access-cycle Prdata/sel_err into a scoreboard. A monitor
// pops and compares on every access cycle. The reference model is a plain
// array of words plus the last read value.
module tb_modport_apb_slave;

  logic        clk;
  logic        Hresetn;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        sel_err;

  modport_apb_slave #(.NSLV(4), .DEPTH(16), .DATA_W(32)) dut (
    .clk     (clk),
    .Hresetn (Hresetn),
    .Pselx   (Pselx),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .sel_err (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  // Reference model.
  logic [31:0] mem [4][16];
  logic [31:0] m_prd;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 16; w++)
        mem[s][w] = 32'h0;
    m_prd = 32'h0;
    m_err = 1'b0;
  endtask

  function automatic int sel_to_idx(input logic [3:0] sel);
    int r = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) r = i;
    return r;
  endfunction

  // One full APB transfer; entered and left 1 time unit after a rising edge.
  task automatic xfer(input string name, input logic [3:0] sel, input logic [31:0] addr,
                      input logic wr, input logic [31:0] data, input bit b2b);
    int  ones = $countones(sel);
    int  widx = int'(addr[5:2]);
    exp_t x;
    // Setup cycle: Pwdata carries junk here since it must only be sampled later.
    Pselx   = sel;
    Paddr   = addr;
    Pwrite  = wr;
    Pwdata  = $urandom;
    Penable = 1'b0;
    if (ones == 1) begin
      m_err = 1'b0;
      if (!wr) m_prd = mem[sel_to_idx(sel)][widx];
    end else begin
      m_prd = 32'h0;
      m_err = 1'b1;
    end
    x.prdata = m_prd;
    x.err    = m_err;
    x.name   = name;
    sb.push_back(x);
    @(posedge clk); #1;
    // Access cycle.
    Penable = 1'b1;
    Pwdata  = data;
    @(posedge clk); #1;
    if (wr && ones == 1) mem[sel_to_idx(sel)][widx] = data;
    if (!b2b) begin
      Pselx   = 4'b0;
      Penable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    Pselx   = 4'b0;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every access cycle presents a response to compare.
  always @(negedge clk) begin
    if (mon_en && Hresetn && Penable && (Pselx != 4'b0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=access_cycle expected=no_access_cycle");
      end else begin
        e = sb.pop_front();
        check({e.name, "_prdata"}, Prdata, e.prdata);
        check({e.name, "_sel_err"}, {31'b0, sel_err}, {31'b0, e.err});
      end
    end
  end

  // Bound on total run time.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rsel;
    logic [31:0] raddr;
    Hresetn = 1'b0;
    Pselx   = 4'b0;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = 32'h0;
    Pwdata  = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_prdata", Prdata, 32'h0);
    check("reset_sel_err", {31'b0, sel_err}, 32'h0);
    Hresetn = 1'b1;
    @(posedge clk); #1;

    // Abort: reset during the access cycle of a write.
    Pselx = 4'b0001; Paddr = 32'h10; Pwrite = 1'b1; Pwdata = 32'h0; Penable = 1'b0;
    @(posedge clk); #1;
    Penable = 1'b1; Pwdata = 32'h12345678;
    #2 Hresetn = 1'b0;
    #1;
    check("abort_prdata", Prdata, 32'h0);
    check("abort_sel_err", {31'b0, sel_err}, 32'h0);
    @(posedge clk); #1;
    idle(1);
    Hresetn = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle(1);
    // A Penable without setup right after reset must be ignored.
    Pselx = 4'b0001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'hBAD0BAD0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    idle(1);
    mon_en = 1'b1;
    xfer("abort_readback", 4'b0001, 32'h10, 1'b0, 32'h0, 1'b0);

    // Directed write/read.
    xfer("wr_deadbeef", 4'b0001, 32'h04, 1'b1, 32'hDEADBEEF, 1'b0);
    xfer("rd_deadbeef", 4'b0001, 32'h04, 1'b0, 32'h0, 1'b0);
    // Bank isolation.
    xfer("wr_bank1", 4'b0010, 32'h3C, 1'b1, 32'h11111111, 1'b0);
    xfer("wr_bank3", 4'b1000, 32'h3C, 1'b1, 32'h22222222, 1'b0);
    xfer("rd_bank1", 4'b0010, 32'h3C, 1'b0, 32'h0, 1'b0);
    xfer("rd_bank3", 4'b1000, 32'h3C, 1'b0, 32'h0, 1'b0);
    xfer("rd_bank0_3c", 4'b0001, 32'h3C, 1'b0, 32'h0, 1'b0);
    // Back-to-back write then read.
    xfer("b2b_wr", 4'b0100, 32'h08, 1'b1, 32'hA5A5A5A5, 1'b1);
    xfer("b2b_rd", 4'b0100, 32'h08, 1'b0, 32'h0, 1'b0);
    // Illegal select.
    xfer("pre_wr0", 4'b0001, 32'h00, 1'b1, 32'h0000AAAA, 1'b0);
    xfer("pre_wr1", 4'b0010, 32'h00, 1'b1, 32'h0000BBBB, 1'b0);
    xfer("pre_rd1", 4'b0010, 32'h00, 1'b0, 32'h0, 1'b0);
    xfer("illegal_wr", 4'b0011, 32'h00, 1'b1, 32'hFFFFFFFF, 1'b0);
    xfer("post_rd0", 4'b0001, 32'h00, 1'b0, 32'h0, 1'b0);
    xfer("post_rd1", 4'b0010, 32'h00, 1'b0, 32'h0, 1'b0);

    // Randomized traffic with a narrow address range to force reuse.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        rsel = 4'b0001 << $urandom_range(0, 3);
      end else begin
        rsel = 4'($urandom);
        while ($countones(rsel) < 2) rsel = 4'($urandom);
      end
      raddr = $urandom;
      if ($urandom_range(0, 1) == 1) raddr[5:2] = 4'($urandom_range(0, 3));
      xfer("rand", rsel, raddr, 1'($urandom), $urandom, 1'($urandom));
    end
    idle(2);

    // Mid-cycle reset with non-zero Prdata, then every word reads back zero.
    xfer("pre_rst_wr", 4'b0001, 32'h04, 1'b1, 32'hCAFEF00D, 1'b0);
    xfer("pre_rst_rd", 4'b0001, 32'h04, 1'b0, 32'h0, 1'b0);
    @(negedge clk); #2;
    Hresetn = 1'b0;
    #1;
    check("midrst_prdata", Prdata, 32'h0);
    check("midrst_sel_err", {31'b0, sel_err}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    Hresetn = 1'b1;
    idle(1);
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 16; w++)
        xfer("zero_rd", 4'b0001 << s, 32'(w << 2), 1'b0, 32'h0, 1'b1);
    idle(3);

    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
